// File: rtl/hov_pkg.sv
// hov_pkg: shared types and default widths for the memory loader.
package hov_pkg;
  localparam int DEF_PROG_AW = 8;
  localparam int DEF_IN_AW = 13;
  localparam int DEF_IN_DW = 12;
  typedef enum logic [1:0] {HOLD, RUN, LOAD, SETTLE} state_t;
  typedef enum logic [1:0] {TGT_NONE, TGT_PROG, TGT_IN1, TGT_IN2} tgt_t;
endpackage

// File: rtl/hov_quiet_timer.sv
// hov_quiet_timer: counts idle cycles in SETTLE; done on the last quiet cycle.
module hov_quiet_timer #(
  parameter int QUIET_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int W = QUIET_CYCLES > 1 ? $clog2(QUIET_CYCLES) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign done = cnt == W'(QUIET_CYCLES - 1);
endmodule

// File: rtl/hov_mem_loader.sv
// hov_mem_loader: turns register-interface commits into one-cycle RAM write strobes and holds the CPU until the bus settles.
// Define HOV_LOADER_CHECKSUM_EN to add load_checksum, a running sum of every written word.
module hov_mem_loader
  import hov_pkg::*;
#(
  parameter int PROG_AW = DEF_PROG_AW,
  parameter int IN_AW = DEF_IN_AW,
  parameter int IN_DW = DEF_IN_DW,
  parameter int QUIET_CYCLES = 1024,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic program_set,
  input  logic input1_set,
  input  logic input2_set,
  input  logic [PROG_AW-1:0] program_addr,
  input  logic [31:0] program_data,
  input  logic [IN_AW-1:0] input_addr,
  input  logic [IN_DW-1:0] input_data,
  input  logic run_req,
  output logic prog_we,
  output logic [PROG_AW-1:0] prog_waddr,
  output logic [31:0] prog_wdata,
  output logic in1_we,
  output logic in2_we,
  output logic [IN_AW-1:0] in_waddr,
  output logic [IN_DW-1:0] in_wdata,
  output logic cpu_hold,
  output logic busy,
  output logic [CNT_W-1:0] load_count
`ifdef HOV_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] load_checksum
`endif
);
  localparam int TAW = PROG_AW > IN_AW ? PROG_AW : IN_AW;
  logic [2:0] sets, sets_d;
  logic [PROG_AW-1:0] r_prog_addr;
  logic [31:0] r_prog_data;
  logic [IN_AW-1:0] r_in_addr;
  logic [IN_DW-1:0] r_in_data;
  tgt_t tgt, last_tgt;
  logic [TAW-1:0] cur_addr, last_addr;
  logic [31:0] cur_data, last_data;
  logic last_valid, wr, anyset, done;
  state_t state, state_nx;

  always_ff @(posedge clk)
    if (!rst_n) begin
      sets <= '0;
      sets_d <= '0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_in_addr <= '0;
      r_in_data <= '0;
    end else begin
      sets <= {program_set, input1_set, input2_set};
      sets_d <= sets;
      r_prog_addr <= program_addr;
      r_prog_data <= program_data;
      r_in_addr <= input_addr;
      r_in_data <= input_data;
    end

  assign anyset = |sets;

  // a write fires only when the committed tuple is new since the last write
  always_comb begin
    tgt = sets[2] ? TGT_PROG : sets[1] ? TGT_IN1 : sets[0] ? TGT_IN2 : TGT_NONE;
    cur_addr = tgt == TGT_PROG ? TAW'(r_prog_addr) : TAW'(r_in_addr);
    cur_data = tgt == TGT_PROG ? r_prog_data : 32'(r_in_data);
    wr = tgt != TGT_NONE &&
         (!last_valid || tgt != last_tgt || cur_addr != last_addr || cur_data != last_data);
  end

  always_comb begin
    state_nx = state;
    case (state)
      HOLD:    state_nx = anyset ? LOAD : run_req ? RUN : HOLD;
      RUN:     state_nx = anyset ? LOAD : !run_req ? HOLD : RUN;
      LOAD:    state_nx = anyset ? LOAD : SETTLE;
      default: state_nx = anyset ? LOAD : !done ? SETTLE : run_req ? RUN : HOLD;
    endcase
  end

  hov_quiet_timer #(.QUIET_CYCLES(QUIET_CYCLES)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != SETTLE || anyset),
    .en(state == SETTLE),
    .done(done)
  );

  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= HOLD;
      cpu_hold <= 1'b1;
      busy <= 1'b0;
      prog_we <= 1'b0;
      in1_we <= 1'b0;
      in2_we <= 1'b0;
      prog_waddr <= '0;
      prog_wdata <= '0;
      in_waddr <= '0;
      in_wdata <= '0;
      last_valid <= 1'b0;
      last_tgt <= TGT_NONE;
      last_addr <= '0;
      last_data <= '0;
      load_count <= '0;
    end else begin
      state <= state_nx;
      cpu_hold <= state_nx != RUN;
      busy <= state_nx == LOAD || state_nx == SETTLE;
      prog_we <= wr && tgt == TGT_PROG;
      in1_we <= wr && tgt == TGT_IN1;
      in2_we <= wr && tgt == TGT_IN2;
      if (wr && tgt == TGT_PROG) begin
        prog_waddr <= r_prog_addr;
        prog_wdata <= r_prog_data;
      end
      if (wr && tgt != TGT_PROG) begin
        in_waddr <= r_in_addr;
        in_wdata <= r_in_data;
      end
      // any set dropping forgets the last tuple so an identical re-commit is rewritten
      if (wr) begin
        last_valid <= 1'b1;
        last_tgt <= tgt;
        last_addr <= cur_addr;
        last_data <= cur_data;
      end else if (|(sets_d & ~sets)) last_valid <= 1'b0;
      if (wr && !(&load_count)) load_count <= load_count + CNT_W'(1);
    end

`ifdef HOV_LOADER_CHECKSUM_EN
  always_ff @(posedge clk)
    if (!rst_n) load_checksum <= '0;
    else if (wr) load_checksum <= load_checksum + cur_data;
`endif
endmodule

// File: tb/tb_hov_mem_loader.sv
// tb_hov_mem_loader: directed vector table plus hand sequences for settle, re-commit and reset corners.
module tb_hov_mem_loader;
  logic clk = 0, rst_n = 0;
  logic program_set = 0, input1_set = 0, input2_set = 0, run_req = 0;
  logic [7:0] program_addr = 0;
  logic [31:0] program_data = 0;
  logic [12:0] input_addr = 0;
  logic [11:0] input_data = 0;
  logic prog_we, in1_we, in2_we, cpu_hold, busy;
  logic [7:0] prog_waddr;
  logic [31:0] prog_wdata;
  logic [12:0] in_waddr;
  logic [11:0] in_wdata;
  logic [15:0] load_count;
`ifdef HOV_LOADER_CHECKSUM_EN
  logic [31:0] load_checksum;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  hov_mem_loader #(.QUIET_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .program_set(program_set), .input1_set(input1_set), .input2_set(input2_set),
    .program_addr(program_addr), .program_data(program_data),
    .input_addr(input_addr), .input_data(input_data), .run_req(run_req),
    .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
    .in1_we(in1_we), .in2_we(in2_we), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .load_count(load_count)
`ifdef HOV_LOADER_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  typedef struct {
    logic ps, i1, i2;
    logic [7:0] pa;
    logic [31:0] pd;
    logic [12:0] ia;
    logic [11:0] id;
    logic run;
    logic pwe, i1we, i2we, hold, bsy;
    logic [15:0] cnt;
    logic [7:0] pwa;
  } vec_t;
  vec_t tv[16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (cpu_hold && n < 200) begin
      step();
      n++;
    end
  endtask

  int n, strobes, bad;

  initial begin
    tv[0]  = '{0,0,0,8'h00,32'h0,13'h0,12'h0,0, 0,0,0,1,0,16'd0,8'h00};
    tv[1]  = '{1,0,0,8'h10,32'hDEADBEEF,13'h0,12'h0,0, 0,0,0,1,0,16'd0,8'h00};
    tv[2]  = '{1,0,0,8'h10,32'hDEADBEEF,13'h0,12'h0,0, 1,0,0,1,1,16'd1,8'h10};
    tv[3]  = '{1,0,0,8'h10,32'hDEADBEEF,13'h0,12'h0,0, 0,0,0,1,1,16'd1,8'h10};
    tv[4]  = '{1,0,0,8'h11,32'hDEADBEEF,13'h0,12'h0,0, 0,0,0,1,1,16'd1,8'h10};
    tv[5]  = '{1,0,0,8'h11,32'hDEADBEEF,13'h0,12'h0,0, 1,0,0,1,1,16'd2,8'h11};
    tv[6]  = '{0,0,0,8'h11,32'hDEADBEEF,13'h0,12'h0,0, 0,0,0,1,1,16'd2,8'h11};
    tv[7]  = '{1,0,0,8'h11,32'hDEADBEEF,13'h0,12'h0,0, 0,0,0,1,1,16'd2,8'h11};
    tv[8]  = '{1,0,0,8'h11,32'hDEADBEEF,13'h0,12'h0,0, 1,0,0,1,1,16'd3,8'h11};
    tv[9]  = '{1,1,0,8'h11,32'hDEADBEEF,13'h5,12'h5A5,0, 0,0,0,1,1,16'd3,8'h11};
    tv[10] = '{0,1,0,8'h11,32'hDEADBEEF,13'h5,12'h5A5,0, 0,0,0,1,1,16'd3,8'h11};
    tv[11] = '{0,1,0,8'h11,32'hDEADBEEF,13'h5,12'h5A5,0, 0,1,0,1,1,16'd4,8'h11};
    tv[12] = '{0,0,1,8'h11,32'hDEADBEEF,13'h5,12'h5A5,0, 0,0,0,1,1,16'd4,8'h11};
    tv[13] = '{0,0,1,8'h11,32'hDEADBEEF,13'h5,12'h5A5,0, 0,0,1,1,1,16'd5,8'h11};
    tv[14] = '{0,0,0,8'h11,32'hDEADBEEF,13'h5,12'h5A5,0, 0,0,0,1,1,16'd5,8'h11};
    tv[15] = '{0,0,0,8'h11,32'hDEADBEEF,13'h5,12'h5A5,0, 0,0,0,1,1,16'd5,8'h11};

    // reset values, then release straight into RUN
    run_req = 1;
    step();
    chk("rst_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", load_count, 0);
    chk("rst_we", {prog_we, in1_we, in2_we}, 0);
    rst_n = 1;
    step();
    chk("run_hold", cpu_hold, 0);
    run_req = 0;
    step();
    chk("hold_again", cpu_hold, 1);

    for (int i = 0; i < 16; i++) begin
      {program_set, input1_set, input2_set} = {tv[i].ps, tv[i].i1, tv[i].i2};
      program_addr = tv[i].pa;
      program_data = tv[i].pd;
      input_addr = tv[i].ia;
      input_data = tv[i].id;
      run_req = tv[i].run;
      step();
      chk($sformatf("v%0d_we", i), {prog_we, in1_we, in2_we}, {tv[i].pwe, tv[i].i1we, tv[i].i2we});
      chk($sformatf("v%0d_hold_busy", i), {cpu_hold, busy}, {tv[i].hold, tv[i].bsy});
      chk($sformatf("v%0d_cnt", i), load_count, tv[i].cnt);
      chk($sformatf("v%0d_pwaddr", i), prog_waddr, tv[i].pwa);
    end
    chk("tbl_pwdata", prog_wdata, 32'hDEADBEEF);
    chk("tbl_in", {in_waddr, in_wdata}, {13'h5, 12'h5A5});

    // SETTLE of 16 quiet cycles, then release
    run_req = 1;
    wait_release(n);
    chk("settle_len", n, 16);
    chk("settle_busy", busy, 0);

    // in RUN: input2 pulse, then identical re-commit after a gap
    input_addr = 13'h003;
    input_data = 12'h123;
    input2_set = 1;
    step();
    chk("b_hold_e1", cpu_hold, 0);
    input2_set = 0;
    step();
    chk("b_in2_e2", in2_we, 1);
    chk("b_hold_e2", cpu_hold, 1);
    chk("b_in_e2", {in_waddr, in_wdata}, {13'h003, 12'h123});
    input2_set = 1;
    step();
    chk("b_in2_e3", in2_we, 0);
    input2_set = 0;
    step();
    chk("b_in2_e4", in2_we, 1);
    chk("b_cnt_e4", load_count, 7);

    // program_set reasserted at settle cycle 8 restarts the quiet count
    repeat (8) step();
    chk("c_busy_mid", {busy, cpu_hold}, 2'b11);
    program_addr = 8'h20;
    program_data = 32'hA5;
    program_set = 1;
    step();
    program_set = 0;
    step();
    chk("c_pwe", {prog_we, prog_waddr}, {1'b1, 8'h20});
    wait_release(n);
    chk("c_restart_len", n, 17);

    // 8192-word auto-increment sweep into input 1
    rst_n = 0;
    step();
    rst_n = 1;
    run_req = 0;
    input_data = 12'h5A5;
    strobes = 0;
    bad = 0;
    for (int k = 1; k <= 8194; k++) begin
      input1_set = k <= 8192;
      input_addr = k <= 8192 ? 13'(k - 1) : 13'h1FFF;
      step();
      if (in1_we) begin
        if (in_waddr !== 13'(strobes) || in_wdata !== 12'h5A5) bad++;
        strobes++;
      end
      if (prog_we || in2_we) bad++;
    end
    chk("sweep_strobes", strobes, 8192);
    chk("sweep_order", bad, 0);
    chk("sweep_cnt", load_count, 8192);

    // two program writes, reset during SETTLE
    rst_n = 0;
    step();
    rst_n = 1;
    program_set = 1;
    program_addr = 8'h30;
    program_data = 32'h1;
    step();
    program_addr = 8'h31;
    program_data = 32'hFFFFFFFF;
    step();
`ifdef HOV_LOADER_CHECKSUM_EN
    chk("sum_first", load_checksum, 32'h1);
`endif
    program_set = 0;
    step();
    chk("d_pw", {prog_waddr, prog_wdata}, {8'h31, 32'hFFFFFFFF});
    chk("d_cnt", load_count, 2);
    step();
    step();
    chk("d_settle", {busy, cpu_hold}, 2'b11);
`ifdef HOV_LOADER_CHECKSUM_EN
    chk("sum_wrap", load_checksum, 32'h0);
`endif
    rst_n = 0;
    step();
    chk("r_we", {prog_we, in1_we, in2_we}, 0);
    chk("r_pw", {prog_waddr, prog_wdata}, 0);
    chk("r_in", {in_waddr, in_wdata}, 0);
    chk("r_state", {cpu_hold, busy, load_count}, {2'b10, 16'd0});
`ifdef HOV_LOADER_CHECKSUM_EN
    chk("r_sum", load_checksum, 0);
`endif
    rst_n = 1;
    step();
    step();
    chk("r_hold_idle", {cpu_hold, busy}, 2'b10);

    // reset drops a strobe that is one edge from issuing
    program_addr = 8'h40;
    program_data = 32'h77;
    program_set = 1;
    step();
    program_set = 0;
    rst_n = 0;
    step();
    chk("drop_we", {prog_we, load_count}, 0);
    rst_n = 1;
    step();
    chk("drop_after", {prog_we, load_count}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
